load_store_unit: RTL
====================

# load_store_unit

Multi-cycle load/store unit between the CPU execute stage and the word-organised data memory. Takes one RISC-V load/store request at a time (LB/LH/LW/LBU/LHU/SB/SH/SW) and drives the memory with full-word accesses only, using memory funct 3'b010. Byte and halfword stores are done as read-modify-write; loads are extracted and sign- or zero-extended. Misaligned or illegal requests are rejected with an error response and cause no memory activity.

## Interface
- DATA_WIDTH, 32, data word width
- ADDR_WIDTH, 32, byte address width
- clk  in  1  system clock, all state on posedge
- reset  in  1  synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  high only in IDLE; request accepted when req_valid && req_ready
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RISC-V funct3 of the load/store
- req_addr  in  ADDR_WIDTH  byte address
- req_wdata  in  DATA_WIDTH  store data, right-aligned
- resp_valid  out  1  one-cycle completion pulse
- resp_err  out  1  valid with resp_valid; misaligned or illegal funct3
- resp_rdata  out  DATA_WIDTH  extended load data, valid with resp_valid; 0 for stores and errors
- mem_addr  out  ADDR_WIDTH  word-aligned address, bits [1:0] always 0
- mem_wr_en  out  1  word write strobe
- mem_wr_data  out  DATA_WIDTH  full word to write
- mem_funct  out  3  constant 3'b010
- mem_rd_data  in  DATA_WIDTH  combinational word read of mem_addr

## Operation
- On accept: latch we, funct3, addr, wdata. These registers drive all later states.
- Legal loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Legal stores: 000, 001, 010. All other codes set err.
- Misaligned: halfword with addr[0]=1; word with addr[1:0]!=0. These also set err.
- FSM states:
  - IDLE: on accept, go to RESP if err. Otherwise go to WRITE for SW, and READ for all loads and for SB/SH.
  - READ: drive mem_addr. Capture mem_rd_data into word_q at the clock edge. Go to WRITE for a store, else RESP.
  - WRITE: mem_wr_en=1 and mem_addr driven. SW writes wdata. SB/SH write word_q with lane (addr[1:0]) replaced by wdata[7:0] or wdata[15:0], other bytes kept. Go to RESP.
  - RESP: resp_valid=1, then go to IDLE.
- Load extraction: byte lane = addr[1:0]; half lane = addr[1]. LB/LH sign-extend, LBU/LHU zero-extend, LW passes the word through.
- There is no response backpressure. The consumer must accept resp_valid in the cycle it is high.

## Timing
- Reset values: state IDLE, req_ready=1 after reset, resp_valid=0, resp_err=0, resp_rdata=0, mem_wr_en=0, mem_addr=0, mem_wr_data=0, latches 0.
- Outputs are decoded from registered state and latches. There is no combinational path from req_* to mem_*.
- Latency from the accept edge to the resp_valid cycle:
  - load: 2 cycles
  - SW: 2 cycles
  - SB/SH: 3 cycles
  - error: 1 cycle
- Throughput: the next request can be accepted in the cycle after RESP, so req_ready stays low through RESP.
- Back-to-back: a store to word W followed by a load of W returns the new data, because the write commits at the end of WRITE.
- Reset mid-operation: state returns to IDLE at the sampling edge. If reset is sampled in WRITE, that edge's memory write still commits and no response is produced. Reset in READ causes no write.
- req_valid while busy is ignored, not queued.

## Structure
- Package lsu_pkg:
  - funct3 constants (F3_B=3'b000, F3_H=3'b001, F3_W=3'b010, F3_BU=3'b100, F3_HU=3'b101)
  - MEM_FUNCT_WORD=3'b010
  - state encoding IDLE/READ/WRITE/RESP
- Sub-module lsu_align (combinational):
  - merge(word, wdata, funct3, lane) gives the store word
  - extract(word, funct3, lane) gives the extended load value
  - Instantiated once; the FSM stays in load_store_unit.

## Test plan
- Reset, then LW at 0x10 with memory word 4 = 0xDEADBEEF -> mem_addr=0x10; resp_valid 2 cycles after accept with resp_rdata=0xDEADBEEF, resp_err=0.
- LB at 0x13, LBU at 0x13, and LH at 0x12 on the same word -> 0xFFFFFFDE, 0x000000DE, 0xFFFFDEAD.
- SB 0x55 at 0x21 with word 8 = 0x11223344 -> one READ, then WRITE with mem_wr_data=0x11225544; resp after 3 cycles; a following LW at 0x20 returns 0x11225544.
- SH 0xABCD at 0x22 over 0x11223344 -> 0xABCD3344. SW 0xCAFEF00D at 0x24 -> single write, no READ.
- LW at 0x02, LH at 0x01, funct3 3'b011, and store with funct3 3'b100 -> each gives resp_err=1 one cycle after accept, resp_rdata=0, and mem_wr_en never asserted.
- Assert reset during WRITE of an SB -> the write commits, no resp_valid, req_ready=1 the next cycle. Hold req_valid during a busy load -> exactly one response.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
// Holds the funct3 codes, the memory access code and the FSM state encoding.
// Also provides the request legality/alignment check used at accept time.
package lsu_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [2:0] MEM_FUNCT_WORD = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_RESP  = 2'd3
  } lsu_state_e;

  // High when the request is an illegal funct3 for its direction or misaligned.
  function automatic logic req_error(input logic we, input logic [2:0] f3,
                                     input logic [1:0] lo);
    logic legal;
    logic misaligned;
    if (we) legal = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    else    legal = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                    (f3 == F3_BU) || (f3 == F3_HU);
    misaligned = (((f3 == F3_H) || (f3 == F3_HU)) && lo[0]) ||
                 ((f3 == F3_W) && (lo != 2'b00));
    return !legal || misaligned;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Bundle of request, response and data-memory signals of the load/store unit.
// The slave modport is the unit itself; master is the CPU/memory side.
// No flow control beyond req_valid/req_ready; responses cannot be stalled.
interface load_store_unit_if;
  import lsu_pkg::*;

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [2:0]            req_funct3;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;

  logic                  resp_valid;
  logic                  resp_err;
  logic [DATA_WIDTH-1:0] resp_rdata;

  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_wr_en;
  logic [DATA_WIDTH-1:0] mem_wr_data;
  logic [2:0]            mem_funct;
  logic [DATA_WIDTH-1:0] mem_rd_data;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rd_data,
    output req_ready, resp_valid, resp_err, resp_rdata,
           mem_addr, mem_wr_en, mem_wr_data, mem_funct
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rd_data,
    input  req_ready, resp_valid, resp_err, resp_rdata,
           mem_addr, mem_wr_en, mem_wr_data, mem_funct
  );

endinterface

// File: rtl/lsu_align.sv
// Byte/halfword lane steering: store-word merge and load extraction.
// Purely combinational, zero latency.
// No handshake; results follow the inputs.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [DATA_WIDTH-1:0] word_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [2:0]            funct3_i,
  input  logic [1:0]            lane_i,
  output logic [DATA_WIDTH-1:0] store_word_o,
  output logic [DATA_WIDTH-1:0] load_data_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Replace the addressed lane of the old word with the store data.
  always_comb begin
    store_word_o = word_i;
    case (funct3_i)
      F3_B:    store_word_o[8*lane_i +: 8] = wdata_i[7:0];
      F3_H:    store_word_o[16*lane_i[1] +: 16] = wdata_i[15:0];
      default: store_word_o = wdata_i;
    endcase
  end

  // Pick the addressed lane out of the read word and extend it.
  always_comb begin
    byte_v = word_i[8*lane_i +: 8];
    half_v = word_i[16*lane_i[1] +: 16];
    case (funct3_i)
      F3_B:    load_data_o = {{24{byte_v[7]}}, byte_v};
      F3_H:    load_data_o = {{16{half_v[15]}}, half_v};
      F3_BU:   load_data_o = {24'd0, byte_v};
      F3_HU:   load_data_o = {16'd0, half_v};
      default: load_data_o = word_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle load/store unit issuing full-word memory accesses only.
// Latency accept->resp: error 1, load 2, SW 2, SB/SH 3 (read-modify-write).
// One request at a time; req_ready only in IDLE, responses cannot be stalled.
module load_store_unit
  import lsu_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  load_store_unit_if.slave  bus
);

  lsu_state_e            state_q, state_d;
  logic                  we_q;
  logic [2:0]            f3_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] word_q;
  logic                  err_q;
  logic                  accept;
  logic                  req_err;
  logic [DATA_WIDTH-1:0] store_word;
  logic [DATA_WIDTH-1:0] load_data;

  assign accept  = (state_q == ST_IDLE) && bus.req_valid;
  assign req_err = req_error(bus.req_we, bus.req_funct3, bus.req_addr[1:0]);

  lsu_align u_align (
    .word_i       (word_q),
    .wdata_i      (wdata_q),
    .funct3_i     (f3_q),
    .lane_i       (addr_q[1:0]),
    .store_word_o (store_word),
    .load_data_o  (load_data)
  );

  // State register, request latches and the captured read word.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      f3_q    <= 3'd0;
      addr_q  <= '0;
      wdata_q <= '0;
      word_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        we_q    <= bus.req_we;
        f3_q    <= bus.req_funct3;
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
        err_q   <= req_err;
      end
      if (state_q == ST_READ) word_q <= bus.mem_rd_data;
    end
  end

  // Next state and all outputs, decoded only from registered state.
  always_comb begin
    state_d         = state_q;
    bus.req_ready   = 1'b0;
    bus.resp_valid  = 1'b0;
    bus.resp_err    = 1'b0;
    bus.resp_rdata  = '0;
    bus.mem_wr_en   = 1'b0;
    bus.mem_addr    = {addr_q[ADDR_WIDTH-1:2], 2'b00};
    bus.mem_wr_data = store_word;
    bus.mem_funct   = MEM_FUNCT_WORD;
    case (state_q)
      ST_IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          if (req_err)                                           state_d = ST_RESP;
          else if (bus.req_we && (bus.req_funct3 == F3_W))        state_d = ST_WRITE;
          else                                                   state_d = ST_READ;
        end
      end
      ST_READ:  state_d = we_q ? ST_WRITE : ST_RESP;
      ST_WRITE: begin
        bus.mem_wr_en = 1'b1;
        state_d       = ST_RESP;
      end
      ST_RESP: begin
        bus.resp_valid = 1'b1;
        bus.resp_err   = err_q;
        if (!we_q && !err_q) bus.resp_rdata = load_data;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule
